vga_grid_render: RTL and testbench

- Reader side of the 27-bit per-cell colour bus (reds/greens/blues, 9 cells × 3 bits) written by the keypad colour-select logic.
- Generates 640x480@60 VGA timing from the pixel clock.
- Draws a 3x3 grid of coloured cells with white borders; cell n (1..9) takes its colour from bits [3n-1:3n-3] of each bus.
- Takes one colour snapshot per frame so the picture never tears.

---
 rtl/vga_grid_render.sv | 195 +++++++++++++++++++
 tb/tb_vga_grid_render.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_render.sv
// 640x480@60 VGA timing generator that draws a 3x3 grid of coloured cells with white borders.
// Cell colours come from a per-frame snapshot of the 27-bit reds/greens/blues bus.
module vga_grid_render #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned GRID_X0  = 80,
    parameter int unsigned GRID_Y0  = 0,
    parameter int unsigned CELL_W   = 160,
    parameter int unsigned CELL_H   = 160,
    parameter int unsigned BORDER   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] reds,
    input  logic [26:0] greens,
    input  logic [26:0] blues,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [2:0]  blue,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVis    = 10'(H_ACTIVE);
    localparam logic [9:0] VVis    = 10'(V_ACTIVE);
    localparam logic [9:0] HsFirst = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HsLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VsFirst = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VsLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] Gx0     = 10'(GRID_X0);
    localparam logic [9:0] Gy0     = 10'(GRID_Y0);
    localparam logic [9:0] GridW   = 10'(3 * CELL_W);
    localparam logic [9:0] GridH   = 10'(3 * CELL_H);
    localparam logic [7:0] CxLast  = 8'(CELL_W - 1);
    localparam logic [7:0] CyLast  = 8'(CELL_H - 1);
    localparam logic [7:0] Brd     = 8'(BORDER);

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [7:0]  cx_off_q, cx_off_d, cy_off_q, cy_off_d;
    logic [1:0]  col_q, col_d, row_q, row_d;
    logic [26:0] snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic        frame_start_q, frame_start_d;
    logic        s1_blank_q, s1_blank_d, s1_grid_q, s1_grid_d, s1_border_q, s1_border_d;
    logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [4:0]  s1_base_q, s1_base_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic [2:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic        h_wrap, v_wrap, h_in_grid, v_in_grid, capture;

    always_comb begin
        h_wrap    = (h_cnt_q == HLast);
        v_wrap    = (v_cnt_q == VLast);
        // Unsigned wrap makes positions left/above the grid compare as huge values.
        h_in_grid = ((h_cnt_q - Gx0) < GridW);
        v_in_grid = ((v_cnt_q - Gy0) < GridH);

        h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
        end

        cx_off_d = cx_off_q;
        col_d    = col_q;
        if (h_wrap) begin
            cx_off_d = '0;
            col_d    = '0;
        end else if (h_in_grid) begin
            if (cx_off_q == CxLast) begin
                cx_off_d = '0;
                col_d    = (col_q == 2'd2) ? '0 : col_q + 2'd1;
            end else begin
                cx_off_d = cx_off_q + 8'd1;
            end
        end

        cy_off_d = cy_off_q;
        row_d    = row_q;
        if (h_wrap) begin
            if (v_wrap) begin
                cy_off_d = '0;
                row_d    = '0;
            end else if (v_in_grid) begin
                if (cy_off_q == CyLast) begin
                    cy_off_d = '0;
                    row_d    = (row_q == 2'd2) ? '0 : row_q + 2'd1;
                end else begin
                    cy_off_d = cy_off_q + 8'd1;
                end
            end
        end

        capture  = (h_cnt_q == '0) && (v_cnt_q == VVis);
        snap_r_d = capture ? reds   : snap_r_q;
        snap_g_d = capture ? greens : snap_g_q;
        snap_b_d = capture ? blues  : snap_b_q;
        // Registered pulse lands in the same cycle the counters sit on the capture point.
        frame_start_d = h_wrap && (v_cnt_q == VVis - 10'd1);
    end

    always_comb begin
        s1_blank_d  = (h_cnt_q >= HVis) || (v_cnt_q >= VVis);
        s1_grid_d   = h_in_grid && v_in_grid;
        s1_border_d = (cx_off_q < Brd) || (cy_off_q < Brd);
        // Bit offset of the cell within each bus: row*9 + col*3.
        s1_base_d   = {row_q, 3'b000} + {3'b000, row_q} + {2'b00, col_q, 1'b0} + {3'b000, col_q};
        s1_hs_d     = !((h_cnt_q >= HsFirst) && (h_cnt_q <= HsLast));
        s1_vs_d     = !((v_cnt_q >= VsFirst) && (v_cnt_q <= VsLast));

        hsync_d = s1_hs_q;
        vsync_d = s1_vs_q;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (!s1_blank_q && s1_grid_q) begin
            if (s1_border_q) begin
                red_d   = 3'h7;
                green_d = 3'h7;
                blue_d  = 3'h7;
            end else begin
                red_d   = snap_r_q[s1_base_q +: 3];
                green_d = snap_g_q[s1_base_q +: 3];
                blue_d  = snap_b_q[s1_base_q +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            cx_off_q      <= '0;
            col_q         <= '0;
            cy_off_q      <= '0;
            row_q         <= '0;
            snap_r_q      <= '0;
            snap_g_q      <= '0;
            snap_b_q      <= '0;
            frame_start_q <= 1'b0;
            s1_blank_q    <= 1'b0;
            s1_grid_q     <= 1'b0;
            s1_border_q   <= 1'b0;
            s1_base_q     <= '0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            cx_off_q      <= cx_off_d;
            col_q         <= col_d;
            cy_off_q      <= cy_off_d;
            row_q         <= row_d;
            snap_r_q      <= snap_r_d;
            snap_g_q      <= snap_g_d;
            snap_b_q      <= snap_b_d;
            frame_start_q <= frame_start_d;
            s1_blank_q    <= s1_blank_d;
            s1_grid_q     <= s1_grid_d;
            s1_border_q   <= s1_border_d;
            s1_base_q     <= s1_base_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_grid_render.sv
// Bench for vga_grid_render: a scaled-down instance for whole-frame behaviour and a full-size
// instance for the first lines of 640x480 timing, both checked against a pixel-rule model.
module tb_vga_grid_render;

    typedef struct packed {
        int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
        int gx; int gy; int cw; int ch; int bd;
    } geom_t;

    localparam geom_t GS = '{ha: 64, hf: 4, hs: 8, hb: 4, va: 48, vf: 3, vs: 2, vb: 3,
                             gx: 8, gy: 2, cw: 16, ch: 14, bd: 2};
    localparam geom_t GF = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                             gx: 80, gy: 0, cw: 160, ch: 160, bd: 2};

    localparam int HtS    = GS.ha + GS.hf + GS.hs + GS.hb;
    localparam int FrameS = HtS * (GS.va + GS.vf + GS.vs + GS.vb);
    localparam int CapS   = GS.va * HtS;
    localparam int HtF    = GF.ha + GF.hf + GF.hs + GF.hb;
    localparam int FrameF = HtF * (GF.va + GF.vf + GF.vs + GF.vb);
    localparam int CapF   = GF.va * HtF;
    localparam int Cell1S = (GS.gy + 5) * HtS + GS.gx + 5;

    logic        clk, rst;
    logic [26:0] reds, greens, blues;
    logic        hsync_s, vsync_s, frame_start_s, hsync_f, vsync_f, frame_start_f;
    logic [2:0]  red_s, green_s, blue_s, red_f, green_f, blue_f;

    vga_grid_render #(
        .H_ACTIVE(GS.ha), .H_FP(GS.hf), .H_SYNC(GS.hs), .H_BP(GS.hb),
        .V_ACTIVE(GS.va), .V_FP(GS.vf), .V_SYNC(GS.vs), .V_BP(GS.vb),
        .GRID_X0(GS.gx), .GRID_Y0(GS.gy), .CELL_W(GS.cw), .CELL_H(GS.ch), .BORDER(GS.bd)
    ) dut_s (
        .clk(clk), .rst(rst), .reds(reds), .greens(greens), .blues(blues),
        .hsync(hsync_s), .vsync(vsync_s), .red(red_s), .green(green_s), .blue(blue_s),
        .frame_start(frame_start_s)
    );

    vga_grid_render #(
        .H_ACTIVE(GF.ha), .H_FP(GF.hf), .H_SYNC(GF.hs), .H_BP(GF.hb),
        .V_ACTIVE(GF.va), .V_FP(GF.vf), .V_SYNC(GF.vs), .V_BP(GF.vb),
        .GRID_X0(GF.gx), .GRID_Y0(GF.gy), .CELL_W(GF.cw), .CELL_H(GF.ch), .BORDER(GF.bd)
    ) dut_f (
        .clk(clk), .rst(rst), .reds(reds), .greens(greens), .blues(blues),
        .hsync(hsync_f), .vsync(vsync_f), .red(red_f), .green(green_f), .blue(blue_f),
        .frame_start(frame_start_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pos = raster position of the current cycle; pb = position shown now (-1 = reset).
    int pos_s, pa_s, pb_s, pos_f, pa_f, pb_f;
    logic [26:0] snr_s, sng_s, snb_s, snr_f, sng_f, snb_f;
    int n_chk, n_fail;

    always @(posedge clk) begin
        if (rst) begin
            pos_s <= 0; pa_s <= -1; pb_s <= -1; snr_s <= '0; sng_s <= '0; snb_s <= '0;
            pos_f <= 0; pa_f <= -1; pb_f <= -1; snr_f <= '0; sng_f <= '0; snb_f <= '0;
        end else begin
            pb_s <= pa_s; pa_s <= pos_s; pos_s <= (pos_s + 1) % FrameS;
            pb_f <= pa_f; pa_f <= pos_f; pos_f <= (pos_f + 1) % FrameF;
            if (pos_s == CapS) begin snr_s <= reds; sng_s <= greens; snb_s <= blues; end
            if (pos_f == CapF) begin snr_f <= reds; sng_f <= greens; snb_f <= blues; end
        end
    end

    function automatic logic [10:0] ref_px(input geom_t g, input int p,
                                           input logic [26:0] sr, input logic [26:0] sg,
                                           input logic [26:0] sb);
        int ht, h, v, gx, gy, n;
        logic hs, vs;
        logic [8:0] rgb;
        if (p < 0) return {2'b11, 9'd0};
        ht  = g.ha + g.hf + g.hs + g.hb;
        h   = p % ht;
        v   = p / ht;
        hs  = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hs);
        vs  = !(v >= g.va + g.vf && v < g.va + g.vf + g.vs);
        rgb = '0;
        gx  = h - g.gx;
        gy  = v - g.gy;
        if (h < g.ha && v < g.va && gx >= 0 && gx < 3 * g.cw && gy >= 0 && gy < 3 * g.ch) begin
            if (gx % g.cw < g.bd || gy % g.ch < g.bd) begin
                rgb = '1;
            end else begin
                n   = (gy / g.ch) * 3 + gx / g.cw;
                rgb = {sr[3*n +: 3], sg[3*n +: 3], sb[3*n +: 3]};
            end
        end
        return {hs, vs, rgb};
    endfunction

    task automatic step();
        logic [10:0] exp_s, exp_f;
        @(negedge clk);
        exp_s = ref_px(GS, pb_s, snr_s, sng_s, snb_s);
        exp_f = ref_px(GF, pb_f, snr_f, sng_f, snb_f);
        n_chk++;
        assert ({hsync_s, vsync_s, red_s, green_s, blue_s} === exp_s) else begin
            n_fail++;
            $error("FAIL px_small pos=%0d got=%h exp=%h", pb_s,
                   {hsync_s, vsync_s, red_s, green_s, blue_s}, exp_s);
        end
        n_chk++;
        assert ({hsync_f, vsync_f, red_f, green_f, blue_f} === exp_f) else begin
            n_fail++;
            $error("FAIL px_full pos=%0d got=%h exp=%h", pb_f,
                   {hsync_f, vsync_f, red_f, green_f, blue_f}, exp_f);
        end
        n_chk++;
        assert (frame_start_s === (pos_s == CapS)) else begin
            n_fail++;
            $error("FAIL fs_small pos=%0d got=%b exp=%b", pos_s, frame_start_s, pos_s == CapS);
        end
        n_chk++;
        assert (frame_start_f === (pos_f == CapF)) else begin
            n_fail++;
            $error("FAIL fs_full pos=%0d got=%b exp=%b", pos_f, frame_start_f, pos_f == CapF);
        end
    endtask

    task automatic rand_inputs();
        reds   = 27'($urandom());
        greens = 27'($urandom());
        blues  = 27'($urandom());
    endtask

    task automatic run_until_pb(input int target);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (pb_s != target && k < 10000);
        n_chk++;
        assert (pb_s == target) else begin
            n_fail++;
            $error("FAIL wait_pos got=%0d exp=%0d", pb_s, target);
        end
    endtask

    task automatic check_rgb_s(input string tag, input logic [8:0] exp);
        n_chk++;
        assert ({red_s, green_s, blue_s} === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, {red_s, green_s, blue_s}, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_chk++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        int first_fall, hs_low, vs_low, fs1, fs2, cyc;
        logic prev_hs;
        n_chk = 0; n_fail = 0;
        rst = 1'b1; reds = '0; greens = '0; blues = '0;
        first_fall = -1; hs_low = 0; vs_low = 0; fs1 = -1; fs2 = -1; prev_hs = 1'b1;

        repeat (3) step();
        rst = 1'b0;

        // Two small frames with random colour traffic; cycle 0 is the one in which rst fell.
        for (int c = 0; c < 9000; c++) begin
            step();
            cyc = c + 1;
            if (cyc <= 3 * HtF && !hsync_f) hs_low++;
            if (prev_hs && !hsync_f && first_fall < 0) first_fall = cyc;
            prev_hs = hsync_f;
            if (cyc <= FrameS && !vsync_s) vs_low++;
            if (frame_start_s) begin
                if (fs1 < 0) fs1 = cyc;
                else if (fs2 < 0) fs2 = cyc;
            end
            if ($urandom_range(0, 47) == 0) rand_inputs();
        end
        check_int("first_hsync_fall", first_fall, GF.ha + GF.hf + 2);
        check_int("hsync_low_3_lines", hs_low, 3 * GF.hs);
        check_int("vsync_low_frame", vs_low, GS.vs * HtS);
        check_int("first_frame_start", fs1, CapS);
        check_int("frame_start_period", fs2 - fs1, FrameS);

        // Snapshot isolation on cell 1.
        reds = 27'd1; greens = '0; blues = '0;
        run_until_pb(CapS + 10);
        reds = 27'd6;
        run_until_pb(Cell1S);
        check_rgb_s("cell1_held", 9'o100);
        run_until_pb(CapS + 10);
        run_until_pb(Cell1S);
        check_rgb_s("cell1_updated", 9'o600);

        // Reset at a random point mid-frame; snapshot must come back black.
        repeat ($urandom_range(100, 4000)) begin
            step();
            if ($urandom_range(0, 31) == 0) rand_inputs();
        end
        reds = '1; greens = '1; blues = '1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        run_until_pb(Cell1S);
        check_rgb_s("cell1_after_reset", 9'o000);

        for (int c = 0; c < 9000; c++) begin
            step();
            if ($urandom_range(0, 47) == 0) rand_inputs();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
